// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage in front of the combinational ALU.
// It decodes one RV32I instruction word plus its PC, selects the operands
// (regfile, immediate or PC) and holds them in a one-entry register for EX.
// Optional feature macro: FORWARD_EN adds fwd_valid/fwd_rd/fwd_data.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid/in_ready            fetch handshake (in_ready is combinational)
//   in_instr, in_pc              instruction word and its PC
//   rs1_addr, rs2_addr           regfile read addresses (combinational)
//   rs1_data, rs2_data           regfile read data
//   flush                        drop the held and the incoming instruction
//   out_valid/out_ready          EX handshake
//   out_alu_op, out_a, out_b     ALU op code and operands
//   out_rd, out_rd_we            destination register and write enable
//   out_branch, out_jump         conditional branch / JAL-JALR markers
//   out_target, out_pc           branch/jump target, PC of issued instruction
//   out_illegal                  unsupported encoding

package cpu_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned RAW   = 5;
    localparam int unsigned OPW   = 4;

    localparam logic [OPW-1:0] ALU_ADD  = 4'd0;
    localparam logic [OPW-1:0] ALU_SUB  = 4'd1;
    localparam logic [OPW-1:0] ALU_AND  = 4'd2;
    localparam logic [OPW-1:0] ALU_OR   = 4'd3;
    localparam logic [OPW-1:0] ALU_XOR  = 4'd4;
    localparam logic [OPW-1:0] ALU_SLL  = 4'd5;
    localparam logic [OPW-1:0] ALU_SRL  = 4'd6;
    localparam logic [OPW-1:0] ALU_SRA  = 4'd7;
    localparam logic [OPW-1:0] ALU_SLT  = 4'd8;
    localparam logic [OPW-1:0] ALU_SLTU = 4'd9;
    localparam logic [OPW-1:0] ALU_SEQ  = 4'd10;
    localparam logic [OPW-1:0] ALU_SNE  = 4'd11;
    localparam logic [OPW-1:0] ALU_SGE  = 4'd12;
    localparam logic [OPW-1:0] ALU_SGEU = 4'd13;
    localparam logic [OPW-1:0] ALU_INC  = 4'd14;

    // Payload handed to EX
    typedef struct packed {
        logic [OPW-1:0]  alu_op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [RAW-1:0]  rd;
        logic            rd_we;
        logic            branch;
        logic            jump;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } issue_t;
endpackage

module alu_issue_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC_OUT = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_instr,
    input  logic [XLEN-1:0]     in_pc,
    output logic [RAW-1:0]      rs1_addr,
    output logic [RAW-1:0]      rs2_addr,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic                flush,
`ifdef FORWARD_EN
    input  logic                fwd_valid,
    input  logic [RAW-1:0]      fwd_rd,
    input  logic [XLEN-1:0]     fwd_data,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPW-1:0]      out_alu_op,
    output logic [XLEN-1:0]     out_a,
    output logic [XLEN-1:0]     out_b,
    output logic [RAW-1:0]      out_rd,
    output logic                out_rd_we,
    output logic                out_branch,
    output logic                out_jump,
    output logic [XLEN-1:0]     out_target,
    output logic [XLEN-1:0]     out_pc,
    output logic                out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Value the output register holds whenever it is empty
    function automatic issue_t idle_payload();
        issue_t p;
        p        = '0;
        p.alu_op = ALU_ADD;
        p.pc     = RESET_PC_OUT;
        return p;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RAW-1:0]  rd;
    logic            f7_zero;
    logic            f7_alt;
    logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j, shamt;
    logic [XLEN-1:0] rs1_val, rs2_val;

    issue_t          dec;
    logic            ill;
    logic            wr;

    issue_t          issue_q, issue_n;
    logic            valid_q, valid_n;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rd       = in_instr[11:7];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign f7_zero  = (funct7 == 7'b0000000);
    assign f7_alt   = (funct7 == 7'b0100000);

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
    assign shamt = {27'b0, in_instr[24:20]};

    // Operand source: regfile, optionally overridden by the bypass
`ifdef FORWARD_EN
    assign rs1_val = (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs1_addr)) ? fwd_data : rs1_data;
    assign rs2_val = (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs2_addr)) ? fwd_data : rs2_data;
`else
    assign rs1_val = rs1_data;
    assign rs2_val = rs2_data;
`endif

    // Instruction decode and operand selection
    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.pc     = in_pc;
        ill        = 1'b0;
        wr         = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.a = rs1_val;
                dec.b = rs2_val;
                wr    = 1'b1;
                case (funct3)
                    3'b000: begin
                        dec.alu_op = f7_alt ? ALU_SUB : ALU_ADD;
                        ill        = !(f7_zero || f7_alt);
                    end
                    3'b001: begin dec.alu_op = ALU_SLL;  ill = !f7_zero; end
                    3'b010: begin dec.alu_op = ALU_SLT;  ill = !f7_zero; end
                    3'b011: begin dec.alu_op = ALU_SLTU; ill = !f7_zero; end
                    3'b100: begin dec.alu_op = ALU_XOR;  ill = !f7_zero; end
                    3'b101: begin
                        dec.alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                        ill        = !(f7_zero || f7_alt);
                    end
                    3'b110: begin dec.alu_op = ALU_OR;   ill = !f7_zero; end
                    default: begin dec.alu_op = ALU_AND; ill = !f7_zero; end
                endcase
            end
            OPC_OPIMM: begin
                dec.a = rs1_val;
                dec.b = imm_i;
                wr    = 1'b1;
                case (funct3)
                    3'b000: dec.alu_op = ALU_ADD;  // instr[30] ignored: no SUBI
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        dec.b      = shamt;
                        ill        = !f7_zero;
                    end
                    3'b010: dec.alu_op = ALU_SLT;
                    3'b011: dec.alu_op = ALU_SLTU;
                    3'b100: dec.alu_op = ALU_XOR;
                    3'b101: begin
                        dec.alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                        dec.b      = shamt;
                        ill        = !(f7_zero || f7_alt);
                    end
                    3'b110: dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec.b = imm_u;
                wr    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a = in_pc;
                dec.b = imm_u;
                wr    = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_op = ALU_INC;
                dec.a      = in_pc;
                dec.jump   = 1'b1;
                dec.target = in_pc + imm_j;
                wr         = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_op = ALU_INC;
                dec.a      = in_pc;
                dec.jump   = 1'b1;
                dec.target = (rs1_val + imm_i) & 32'hFFFF_FFFE;
                wr         = 1'b1;
                ill        = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.a      = rs1_val;
                dec.b      = rs2_val;
                dec.branch = 1'b1;
                dec.target = in_pc + imm_b;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_SEQ;
                    3'b001:  dec.alu_op = ALU_SNE;
                    3'b100:  dec.alu_op = ALU_SLT;
                    3'b101:  dec.alu_op = ALU_SGE;
                    3'b110:  dec.alu_op = ALU_SLTU;
                    3'b111:  dec.alu_op = ALU_SGEU;
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase

        dec.rd_we = wr && (rd != '0);
        dec.rd    = wr ? rd : '0;

        // Unsupported encodings issue as a harmless ADD 0,0 with no writeback
        if (ill) begin
            dec         = '0;
            dec.alu_op  = ALU_ADD;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready = !valid_q || out_ready;

    // Pipeline register next state: flush beats load beats drain
    always_comb begin
        valid_n = valid_q;
        issue_n = issue_q;
        if (flush) begin
            valid_n = 1'b0;
            issue_n = idle_payload();
        end else if (in_valid && in_ready) begin
            valid_n = 1'b1;
            issue_n = dec;
        end else if (out_ready) begin
            valid_n = 1'b0;
            issue_n = idle_payload();
        end
    end

    // Pipeline register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            issue_q <= idle_payload();
        end else begin
            valid_q <= valid_n;
            issue_q <= issue_n;
        end
    end

    assign out_valid   = valid_q;
    assign out_alu_op  = issue_q.alu_op;
    assign out_a       = issue_q.a;
    assign out_b       = issue_q.b;
    assign out_rd      = issue_q.rd;
    assign out_rd_we   = issue_q.rd_we;
    assign out_branch  = issue_q.branch;
    assign out_jump    = issue_q.jump;
    assign out_target  = issue_q.target;
    assign out_pc      = issue_q.pc;
    assign out_illegal = issue_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a scoreboard queue holds the
// payload expected for every accepted instruction and is compared in order
// whenever EX takes an output.
module tb_alu_issue_stage;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_branch;
    logic        out_jump;
    logic [31:0] out_target;
    logic [31:0] out_pc;
    logic        out_illegal;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    issue_t      sb[$];
    issue_t      cur;
    issue_t      mon_exp;

    alu_issue_stage #(.RESET_PC_OUT(RST_PC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .flush      (flush),
`ifdef FORWARD_EN
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu_op (out_alu_op),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_rd     (out_rd),
        .out_rd_we  (out_rd_we),
        .out_branch (out_branch),
        .out_jump   (out_jump),
        .out_target (out_target),
        .out_pc     (out_pc),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cur = {out_alu_op, out_a, out_b, out_rd, out_rd_we, out_branch,
                  out_jump, out_target, out_pc, out_illegal};

    function automatic issue_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, input logic we, input logic br,
                                  input logic jp, input logic [31:0] tgt, input logic [31:0] pc,
                                  input logic ill);
        issue_t p;
        p = {op, a, b, rd, we, br, jp, tgt, pc, ill};
        return p;
    endfunction

    // Scoreboard: every output taken by EX must match the oldest expected entry
    always @(negedge clk) begin
        if (reset_n && !flush && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got=%h", cur);
            end else begin
                mon_exp = sb.pop_front();
                if (cur !== mon_exp) begin
                    bad++;
                    $display("FAIL sb_issue got=%h exp=%h", cur, mon_exp);
                end
            end
        end
    end

    // Present one instruction and wait (bounded) until it is accepted
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input issue_t exp);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL accept_timeout instr=%h got_ready=%b exp_ready=1", instr, in_ready);
        end else begin
            sb.push_back(exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF08293;
        in_pc     = 32'h40;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; if (out_pc !== RST_PC) begin bad++; $display("FAIL rst_pc got=%h exp=%h", out_pc, RST_PC); end
        total++; if (out_alu_op !== ALU_ADD || out_a !== 32'd0 || out_b !== 32'd0 || out_target !== 32'd0)
            begin bad++; $display("FAIL rst_payload got=%h", cur); end
        total++; if ({out_rd, out_rd_we, out_branch, out_jump, out_illegal} !== 9'd0)
            begin bad++; $display("FAIL rst_flags got=%h exp=0", {out_rd, out_rd_we, out_branch, out_jump, out_illegal}); end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_release_valid got=%b exp=0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        issue(32'hFFF08293, 32'h40, 32'd10, 32'd0,
              mk(ALU_ADD, 32'd10, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 32'h40, 1'b0));
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_latency got=%b exp=1", out_valid); end
        total++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd31)
            begin bad++; $display("FAIL addi_rs_addr got=%0d/%0d exp=1/31", rs1_addr, rs2_addr); end
        idle(2);
    endtask

    task automatic test_branch_jump();
        issue(32'h00209463, 32'h100, 32'd5, 32'd6,
              mk(ALU_SNE, 32'd5, 32'd6, 5'd0, 1'b0, 1'b1, 1'b0, 32'h108, 32'h100, 1'b0));
        issue(32'h004100E7, 32'h300, 32'h201, 32'd0,
              mk(ALU_INC, 32'h300, 32'd0, 5'd1, 1'b1, 1'b0, 1'b1, 32'h204, 32'h300, 1'b0));
        // JAL x0,+8 at the top of the address space wraps to 4
        issue(32'h0080006F, 32'hFFFF_FFFC, 32'd0, 32'd0,
              mk(ALU_INC, 32'hFFFF_FFFC, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h4, 32'hFFFF_FFFC, 1'b0));
        // BGEU x1,x2,-4
        issue({1'b1, 6'h3F, 5'd2, 5'd1, 3'b111, 4'hE, 1'b1, 7'b1100011}, 32'h20, 32'd3, 32'd4,
              mk(ALU_SGEU, 32'd3, 32'd4, 5'd0, 1'b0, 1'b1, 1'b0, 32'h1C, 32'h20, 1'b0));
        idle(2);
    endtask

    task automatic test_imm_forms();
        issue({7'b0100000, 5'd5, 5'd1, 3'b101, 5'd3, 7'b0010011}, 32'h60, 32'h8000_0000, 32'd0,
              mk(ALU_SRA, 32'h8000_0000, 32'd5, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'h60, 1'b0));
        issue({12'h400, 5'd1, 3'b000, 5'd3, 7'b0010011}, 32'h64, 32'd1, 32'd0,
              mk(ALU_ADD, 32'd1, 32'h400, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'h64, 1'b0));
        issue({20'hABCDE, 5'd7, 7'b0110111}, 32'h68, 32'h55, 32'd0,
              mk(ALU_ADD, 32'd0, 32'hABCD_E000, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 32'h68, 1'b0));
        issue({20'h00012, 5'd8, 7'b0010111}, 32'h6C, 32'd0, 32'd0,
              mk(ALU_ADD, 32'h6C, 32'h0001_2000, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0, 32'h6C, 1'b0));
        issue({12'hFFE, 5'd1, 3'b011, 5'd9, 7'b0010011}, 32'h70, 32'd7, 32'd0,
              mk(ALU_SLTU, 32'd7, 32'hFFFF_FFFE, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 32'h70, 1'b0));
        idle(2);
    endtask

    task automatic test_illegal();
        issue({12'h000, 5'd1, 3'b010, 5'd5, 7'b0000011}, 32'h80, 32'd9, 32'd9,
              mk(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h80, 1'b1));
        issue({7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 32'h84, 32'd9, 32'd9,
              mk(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h84, 1'b1));
        issue({7'b0100000, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011}, 32'h88, 32'd9, 32'd9,
              mk(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h88, 1'b1));
        idle(2);
    endtask

    // R-type ops at one instruction per cycle
    task automatic test_back_to_back();
        logic [2:0]  f3  [10] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111};
        logic [6:0]  f7  [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
        logic [3:0]  ops [10] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                                  ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
        logic [31:0] r1, r2, pc;
        int          c0;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            pc = 32'h200 + 32'(i * 4);
            issue({f7[i], 5'd2, 5'd1, f3[i], 5'd3, 7'b0110011}, pc, r1, r2,
                  mk(ops[i], r1, r2, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, pc, 1'b0));
        end
        total++; if (cyc - c0 !== 10) begin bad++; $display("FAIL b2b_cycles got=%0d exp=10", cyc - c0); end
        idle(2);
    endtask

    task automatic test_backpressure();
        issue_t ea;
        ea = mk(ALU_XOR, 32'h11, 32'h7FF, 5'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'h400, 1'b0);
        out_ready = 1'b0;
        issue({12'h7FF, 5'd1, 3'b100, 5'd4, 7'b0010011}, 32'h400, 32'h11, 32'd0, ea);
        in_instr = {12'h003, 5'd1, 3'b000, 5'd6, 7'b0010011};
        in_pc    = 32'h404;
        rs1_data = 32'h20;
        repeat (3) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
            total++; if (cur !== ea || out_valid !== 1'b1)
                begin bad++; $display("FAIL bp_frozen got=%h exp=%h", cur, ea); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue({12'h003, 5'd1, 3'b000, 5'd6, 7'b0010011}, 32'h404, 32'h20, 32'd0,
              mk(ALU_ADD, 32'h20, 32'd3, 5'd6, 1'b1, 1'b0, 1'b0, 32'd0, 32'h404, 1'b0));
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h404)
            begin bad++; $display("FAIL bp_release got=%b/%h exp=1/00000404", out_valid, out_pc); end
        idle(2);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        issue({12'h001, 5'd1, 3'b000, 5'd2, 7'b0010011}, 32'h500, 32'd1, 32'd0,
              mk(ALU_ADD, 32'd1, 32'd1, 5'd2, 1'b1, 1'b0, 1'b0, 32'd0, 32'h500, 1'b0));
        // Incoming instruction would be accepted (in_ready=1) but flush drops it
        in_instr  = {12'h002, 5'd1, 3'b000, 5'd2, 7'b0010011};
        in_pc     = 32'h504;
        out_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        total++; if (out_pc !== RST_PC) begin bad++; $display("FAIL flush_pc got=%h exp=%h", out_pc, RST_PC); end
        idle(3);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        issue({12'h005, 5'd1, 3'b110, 5'd2, 7'b0010011}, 32'h600, 32'h30, 32'd0,
              mk(ALU_OR, 32'h30, 32'd5, 5'd2, 1'b1, 1'b0, 1'b0, 32'd0, 32'h600, 1'b0));
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        total++; if (out_valid !== 1'b0 || out_pc !== RST_PC || out_a !== 32'd0)
            begin bad++; $display("FAIL midrst got=%b/%h/%h exp=0/%h/0", out_valid, out_pc, out_a, RST_PC); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin bad++; $display("FAIL midrst_release got=%b/%b exp=1/0", in_ready, out_valid); end
    endtask

`ifdef FORWARD_EN
    task automatic test_forward();
        fwd_valid = 1'b1;
        fwd_rd    = 5'd4;
        fwd_data  = 32'd7;
        issue({7'h00, 5'd4, 5'd4, 3'b000, 5'd3, 7'b0110011}, 32'h700, 32'd0, 32'd0,
              mk(ALU_ADD, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'h700, 1'b0));
        issue({7'h00, 5'd5, 5'd4, 3'b000, 5'd3, 7'b0110011}, 32'h704, 32'd0, 32'd9,
              mk(ALU_ADD, 32'd7, 32'd9, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'h704, 1'b0));
        fwd_rd = 5'd0;
        issue({7'h00, 5'd0, 5'd0, 3'b000, 5'd3, 7'b0110011}, 32'h708, 32'd0, 32'd0,
              mk(ALU_ADD, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'h708, 1'b0));
        fwd_valid = 1'b0;
        idle(2);
    endtask
`endif

    initial begin
        clk       = 1'b0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        flush     = 1'b0;
        fwd_valid = 1'b0;
        fwd_rd    = 5'd0;
        fwd_data  = 32'd0;
        out_ready = 1'b1;

        test_reset();
        test_addi();
        test_branch_jump();
        test_imm_forms();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_mid_reset();
`ifdef FORWARD_EN
        test_forward();
`endif
        idle(3);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
